// File: rtl/core_pkg.sv
// Shared types and helpers for the core's data-memory port.
package core_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8;
    localparam int unsigned DMEM_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DATA_WIDTH-1:0]  wdata;
        logic [BE_WIDTH-1:0]    be;
    } dmem_req_t;

    // Stores are judged on the lane pattern alone; loads also check addr[1:0] against the implied size.
    function automatic logic dmem_misaligned(input logic                we,
                                             input logic [1:0]          addr_lo,
                                             input logic [BE_WIDTH-1:0] be);
        logic bad;
        case (be)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: bad = 1'b0;
            4'b0011, 4'b1100:                            bad = !we && addr_lo[0];
            4'b1111:                                     bad = !we && (addr_lo != 2'b00);
            default:                                     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with per-byte write enables.
module dmem_ram
    import core_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter string       INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [BE_WIDTH-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM and keeps its contents across rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder with programmable wait states; define DMEM_ERR_EN to report
// misaligned and out-of-range accesses on rsp_err.
module dmem_responder
    import core_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [7:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

    dmem_state_e           state, state_next;
    logic [7:0]            cnt;
    dmem_req_t             req_q, req_in, cur;
    logic                  err_q, err_in, cur_err;
    logic                  accept, commit, ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign req_in    = '{we: req_we, addr: DMEM_ADDR_W'(req_addr), wdata: req_wdata, be: req_be};

`ifdef DMEM_ERR_EN
    assign err_in  = dmem_misaligned(req_we, req_addr[1:0], req_be)
                   || ((req_addr >> (IDX_W + 2)) != '0);
    assign rsp_err = (state == RESP) && err_q;
`else
    assign err_in  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // With zero wait states the commit edge is the accept edge, so the RAM sees the live request.
    assign cur     = (state == IDLE) ? req_in : req_q;
    assign cur_err = (state == IDLE) ? err_in : err_q;
    assign commit  = (state_next == RESP) && (state != RESP);
    assign ram_we  = commit && cur.we && !cur_err;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 8'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            req_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                req_q <= req_in;
                err_q <= err_in;
                cnt   <= WAIT_INIT;
            end else if (state == WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // The RAM output register is loaded on the commit edge and re-reads the same word while in RESP.
    dmem_ram #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (cur.be),
        .addr  (cur.addr[IDX_W+1:2]),
        .wdata (cur.wdata),
        .rdata (ram_rdata)
    );

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = (state == RESP && !req_q.we && !err_q) ? ram_rdata : '0;

    logic unused_bits;
    assign unused_bits = &{1'b0, req_q.addr, req_addr};

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with no wait states and one with three, sharing clk and rst_n.
module tb_dmem_responder;
    import core_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int          LIMIT = 50;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid [2];
    logic                  req_ready [2];
    logic                  req_we    [2];
    logic [31:0]           req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];
    logic [BE_WIDTH-1:0]   req_be    [2];
    logic                  rsp_valid [2];
    logic                  rsp_ready [2];
    logic [DATA_WIDTH-1:0] rsp_rdata [2];
    logic                  rsp_err   [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata[d], 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err[d]),   32'd0);
    endtask

    // One complete request/response; latency counts cycles from the handshake cycle to rsp_valid.
    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
        req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
        n = 0;
        while (!req_ready[d] && n < LIMIT) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < LIMIT) begin @(negedge clk); lat++; end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(negedge clk);
    endtask

    typedef struct {
        int          d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [18];

    initial begin
        logic [31:0] rd, held;
        logic        er;
        int          lat;
        bit          err_en;

`ifdef DMEM_ERR_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif

        vecs[0]  = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1};
        vecs[1]  = '{0, 1'b0, 32'h10, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0, 1};
        vecs[2]  = '{0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 32'h0, 1'b0, 1};
        vecs[3]  = '{0, 1'b0, 32'h10, 32'h0,        4'b1111, 32'hDEADABEF, 1'b0, 1};
        vecs[4]  = '{0, 1'b1, 32'h14, 32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0, 1};
        vecs[5]  = '{0, 1'b1, 32'h14, 32'h11223344, 4'b1100, 32'h0, 1'b0, 1};
        vecs[6]  = '{0, 1'b0, 32'h14, 32'h0,        4'b0001, 32'h1122A5A5, 1'b0, 1};
        vecs[7]  = '{0, 1'b1, 32'h18, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b0, 1};
        vecs[8]  = '{0, 1'b1, 32'h18, 32'h12345678, 4'b0000, 32'h0, 1'b0, 1};
        vecs[9]  = '{0, 1'b0, 32'h18, 32'h0,        4'b1111, 32'hFFFFFFFF, 1'b0, 1};
        vecs[10] = '{0, 1'b1, 32'h00, 32'h01020304, 4'b1111, 32'h0, 1'b0, 1};
        // Misaligned word load, then an out-of-range load aliasing onto word 0x10.
        vecs[11] = '{0, 1'b0, 32'h12, 32'h0, 4'b1111, err_en ? 32'h0 : 32'hDEADABEF, err_en, 1};
        vecs[12] = '{0, 1'b0, 32'h50, 32'h0, 4'b1111, err_en ? 32'h0 : 32'hDEADABEF, err_en, 1};
        // Store at DEPTH*4: rejected with the error check, otherwise it lands on word 0.
        vecs[13] = '{0, 1'b1, DEPTH * 4, 32'h99999999, 4'b1111, 32'h0, err_en, 1};
        vecs[14] = '{0, 1'b0, 32'h00, 32'h0, 4'b1111, err_en ? 32'h01020304 : 32'h99999999, 1'b0, 1};
        vecs[15] = '{1, 1'b1, 32'h20, 32'h00000000, 4'b1111, 32'h0, 1'b0, 4};
        vecs[16] = '{1, 1'b1, 32'h00, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 4};
        vecs[17] = '{1, 1'b0, 32'h00, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0, 4};

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   req_be[d] = '0;   rsp_ready[d] = 1'b1;
        end

        #12;
        check_idle(0, "reset0");
        check_idle(1, "reset3");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            do_txn(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Wait-state timing and response back-pressure, with a second request held pending.
        @(negedge clk);
        req_we[1] = 1'b0; req_addr[1] = 32'h0; req_be[1] = 4'b1111;
        req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
        check("bp_ready_at_accept", 32'(req_ready[1]), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) req_addr[1] = 32'h4;
            check($sformatf("bp_wait%0d_ready", c), 32'(req_ready[1]), 32'd0);
            check($sformatf("bp_wait%0d_valid", c), 32'(rsp_valid[1]), 32'd0);
        end
        @(negedge clk);
        check("bp_valid_cycle4", 32'(rsp_valid[1]), 32'd1);
        check("bp_rdata_cycle4", rsp_rdata[1], 32'hCAFEF00D);
        held = rsp_rdata[1];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_valid", c), 32'(rsp_valid[1]), 32'd1);
            check($sformatf("bp_hold%0d_rdata", c), rsp_rdata[1], held);
            check($sformatf("bp_hold%0d_err", c), 32'(rsp_err[1]), 32'd0);
            check($sformatf("bp_hold%0d_ready", c), 32'(req_ready[1]), 32'd0);
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("bp_after_valid", 32'(rsp_valid[1]), 32'd0);
        check("bp_after_ready", 32'(req_ready[1]), 32'd1);

        // Reset while a store waits in WAIT: the store is dropped and no response follows.
        @(negedge clk);
        req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678; req_be[1] = 4'b1111;
        req_valid[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        check("rst_in_wait_ready", 32'(req_ready[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle(1, "rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rst_no_rsp%0d", c), 32'(rsp_valid[1]), 32'd0);
        end
        do_txn(1, 1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
        check("rst_dropped_store", rd, 32'h00000000);
        check("rst_dropped_latency", 32'(lat), 32'd4);
        do_txn(0, 1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
        check("rst_mem_kept", rd, 32'hDEADABEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
